// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone host arbiter.
//   state_t  : arbiter FSM states (IDLE, BUSY, ABORT)
//   CNT_W    : width of the stalled-transfer counter
//   GNT_*    : one-hot grant encodings driven on grant_o
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_host_arbiter_if.sv
// Classic single-beat Wishbone bus bundle.
//   cyc, stb, we, adr, dat_w, sel : driven by the bus master
//   ack, err, dat_r               : driven by the bus slave
// modport master : the side that initiates transfers
// modport slave  : the side that responds to transfers
interface wb_host_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            ack;
    logic            err;
    logic [DW-1:0]   dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output ack, err, dat_r
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req_i  : request vector, bit N = master N
//   last_i : index of the master that owned the bus most recently
//   gnt_o  : one-hot pick, GNT_NONE when nobody requests
module rr_arb2
    import wb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // On a tie the master that did not own the bus last time wins.
    always_comb begin
        gnt_o = GNT_NONE;
        case (req_i)
            2'b01:   gnt_o = GNT_M0;
            2'b10:   gnt_o = GNT_M1;
            2'b11:   gnt_o = last_i ? GNT_M0 : GNT_M1;
            default: gnt_o = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/wb_host_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness and a
// stalled-transfer timeout.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   m0, m1        : master ports (management core, logic-analyzer master)
//   s             : slave port towards the SoC
//   grant_o       : one-hot current owner, 00 when idle
//   timeout_o     : one-cycle pulse when a stalled transfer is aborted
module wb_host_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    wb_host_arbiter_if.slave    m0,
    wb_host_arbiter_if.slave    m1,
    wb_host_arbiter_if.master   s,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       req;
    logic [1:0]       pick;
    logic             own;
    logic             own_cyc;
    logic             own_stb;

    assign req     = {m1.cyc & m1.stb, m0.cyc & m0.stb};
    assign own     = grant_q[1];
    assign own_cyc = own ? m1.cyc : m0.cyc;
    assign own_stb = own ? m1.stb : m0.stb;

    rr_arb2 u_rr_arb2 (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // State, grant, last-owner and stall-counter registers.
    // last_q resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter only carries a value while the
    // tenure stays in BUSY; every other path clears it. An ack in the
    // same cycle the limit is reached takes priority over the abort.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick != GNT_NONE) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    last_d  = own;
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end else if (s.ack) begin
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ABORT;
                end else if (own_stb) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ABORT: begin
                last_d  = own;
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    // Slave-side mux: the owner's request is only visible in BUSY, so the
    // slave strobes are forced low in IDLE and during the ABORT cycle.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = {AW{1'b0}};
        s.dat_w = {DW{1'b0}};
        s.sel   = '0;
        if (state_q == BUSY) begin
            if (own) begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.adr   = m1.adr;
                s.dat_w = m1.dat_w;
                s.sel   = m1.sel;
            end else begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.adr   = m0.adr;
                s.dat_w = m0.dat_w;
                s.sel   = m0.sel;
            end
        end
    end

    // Master-side responses: ack and read data reach the owner only, and
    // only in BUSY, so acks arriving in IDLE or ABORT are dropped.
    always_comb begin
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_r = {DW{1'b0}};
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_r = {DW{1'b0}};
        if (state_q == BUSY) begin
            if (grant_q[0]) begin
                m0.ack   = s.ack;
                m0.dat_r = s.dat_r;
            end
            if (grant_q[1]) begin
                m1.ack   = s.ack;
                m1.dat_r = s.dat_r;
            end
        end
        if (state_q == ABORT) begin
            m0.err = grant_q[0];
            m1.err = grant_q[1];
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = (state_q == ABORT);

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Directed self-checking bench for wb_host_arbiter (TIMEOUT = 4).
module tb_wb_host_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] grant_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wb_host_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
    wb_host_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
    wb_host_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

    wb_host_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0;
        m0_bus.adr = '0; m0_bus.dat_w = '0; m0_bus.sel = '0;
        m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0;
        m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.sel = '0;
        s_bus.ack = 0; s_bus.err = 0; s_bus.dat_r = '0;
    endtask

    task automatic req_m0(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = we;
        m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = 4'hF;
    endtask

    task automatic req_m1(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.we = we;
        m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = 4'hF;
    endtask

    task automatic test_reset();
        idle_all();
        req_m0(1'b0, 32'h0000_0100, 32'h0);
        s_bus.ack = 1; s_bus.dat_r = 32'hFFFF_FFFF;
        #3;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        total++; if (s_bus.stb !== 1'b0 || s_bus.cyc !== 1'b0) begin bad++; $display("FAIL reset_s_strobe: got cyc=%b stb=%b want 0/0", s_bus.cyc, s_bus.stb); end
        total++; if (s_bus.adr !== 32'h0) begin bad++; $display("FAIL reset_s_adr: got %h want 0", s_bus.adr); end
        total++; if (m0_bus.ack !== 1'b0 || m0_bus.err !== 1'b0) begin bad++; $display("FAIL reset_m0_resp: got ack=%b err=%b want 0/0", m0_bus.ack, m0_bus.err); end
        total++; if (m0_bus.dat_r !== 32'h0) begin bad++; $display("FAIL reset_m0_dat: got %h want 0", m0_bus.dat_r); end
        idle_all();
        step();
        #2 rst_ni = 1'b1;
        step();
    endtask

    task automatic test_tie();
        req_m0(1'b0, 32'h0000_0200, 32'h0);
        req_m1(1'b0, 32'h0000_0300, 32'h0);
        #1;
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie_idle_grant: got %b want 00", grant_o); end
        step();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tie_first_grant: got %b want 01", grant_o); end
        total++; if (s_bus.adr !== 32'h0000_0200) begin bad++; $display("FAIL tie_first_adr: got %h want 00000200", s_bus.adr); end
        s_bus.ack = 1;
        #1;
        total++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin bad++; $display("FAIL tie_m0_ack: got m0=%b m1=%b want 1/0", m0_bus.ack, m1_bus.ack); end
        step();
        s_bus.ack = 0; m0_bus.cyc = 0; m0_bus.stb = 0;
        step();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie_gap_grant: got %b want 00", grant_o); end
        step();
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL tie_second_grant: got %b want 10", grant_o); end
        total++; if (s_bus.adr !== 32'h0000_0300) begin bad++; $display("FAIL tie_second_adr: got %h want 00000300", s_bus.adr); end
        s_bus.ack = 1;
        #1;
        total++; if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin bad++; $display("FAIL tie_m1_ack: got m1=%b m0=%b want 1/0", m1_bus.ack, m0_bus.ack); end
        step();
        s_bus.ack = 0; m1_bus.cyc = 0; m1_bus.stb = 0;
        step();
        req_m0(1'b0, 32'h0000_0204, 32'h0);
        req_m1(1'b0, 32'h0000_0304, 32'h0);
        step();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tie_third_grant: got %b want 01", grant_o); end
        idle_all();
        step();
        step();
    endtask

    task automatic test_single_read();
        req_m0(1'b0, 32'h0000_0100, 32'h0);
        #1;
        total++; if (s_bus.stb !== 1'b0) begin bad++; $display("FAIL read_no_early_stb: got %b want 0", s_bus.stb); end
        step();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL read_grant: got %b want 01", grant_o); end
        total++; if (s_bus.stb !== 1'b1 || s_bus.adr !== 32'h0000_0100 || s_bus.we !== 1'b0) begin bad++; $display("FAIL read_slave_req: got stb=%b adr=%h we=%b want 1/00000100/0", s_bus.stb, s_bus.adr, s_bus.we); end
        step();
        step();
        s_bus.ack = 1; s_bus.dat_r = 32'hDEAD_BEEF;
        #1;
        total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL read_m0_ack: got %b want 1", m0_bus.ack); end
        total++; if (m0_bus.dat_r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_m0_dat: got %h want deadbeef", m0_bus.dat_r); end
        total++; if (m1_bus.ack !== 1'b0 || m1_bus.dat_r !== 32'h0) begin bad++; $display("FAIL read_m1_quiet: got ack=%b dat=%h want 0/0", m1_bus.ack, m1_bus.dat_r); end
        step();
        s_bus.ack = 0; s_bus.dat_r = '0; m0_bus.cyc = 0; m0_bus.stb = 0;
        #1;
        total++; if (grant_o !== 2'b01 || s_bus.cyc !== 1'b0) begin bad++; $display("FAIL read_cyc_drop: got grant=%b s_cyc=%b want 01/0", grant_o, s_bus.cyc); end
        step();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL read_back_idle: got %b want 00", grant_o); end
    endtask

    task automatic test_back_to_back();
        req_m1(1'b1, 32'h0000_0010, 32'h0000_00A0);
        req_m0(1'b0, 32'h0000_0400, 32'h0);
        step();
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL b2b_grant: got %b want 10", grant_o); end
        for (int i = 0; i < 4; i++) begin
            m1_bus.adr = 32'h10 + 32'(4 * i);
            m1_bus.dat_w = 32'hA0 + 32'(i);
            s_bus.ack = 1;
            #1;
            total++; if (s_bus.adr !== 32'h10 + 32'(4 * i) || s_bus.dat_w !== 32'hA0 + 32'(i) || s_bus.we !== 1'b1) begin bad++; $display("FAIL b2b_beat%0d: got adr=%h dat=%h we=%b", i, s_bus.adr, s_bus.dat_w, s_bus.we); end
            total++; if (grant_o !== 2'b10 || m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin bad++; $display("FAIL b2b_hold%0d: got grant=%b m1ack=%b m0ack=%b want 10/1/0", i, grant_o, m1_bus.ack, m0_bus.ack); end
            step();
        end
        s_bus.ack = 0; m1_bus.cyc = 0; m1_bus.stb = 0;
        #1;
        total++; if (grant_o !== 2'b10 || s_bus.cyc !== 1'b0) begin bad++; $display("FAIL b2b_release: got grant=%b s_cyc=%b want 10/0", grant_o, s_bus.cyc); end
        step();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL b2b_gap: got %b want 00", grant_o); end
        step();
        total++; if (grant_o !== 2'b01 || s_bus.adr !== 32'h0000_0400) begin bad++; $display("FAIL b2b_m0_after: got grant=%b adr=%h want 01/00000400", grant_o, s_bus.adr); end
        idle_all();
        step();
        step();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int pulse_at = -1;
        req_m0(1'b0, 32'h0000_0600, 32'h0);
        step();
        for (int c = 0; c <= 5; c++) begin
            if (timeout_o === 1'b1 || m0_bus.err === 1'b1) begin
                pulses++;
                pulse_at = c;
            end
            if (c == 5) begin
                total++; if (timeout_o !== 1'b1 || m0_bus.err !== 1'b1) begin bad++; $display("FAIL to_pulse: got timeout=%b err=%b want 1/1", timeout_o, m0_bus.err); end
                total++; if (s_bus.stb !== 1'b0 || s_bus.cyc !== 1'b0) begin bad++; $display("FAIL to_stb_low: got cyc=%b stb=%b want 0/0", s_bus.cyc, s_bus.stb); end
                total++; if (m1_bus.err !== 1'b0) begin bad++; $display("FAIL to_m1_err: got %b want 0", m1_bus.err); end
                m0_bus.cyc = 0; m0_bus.stb = 0;
            end
            step();
        end
        total++; if (pulses !== 1 || pulse_at !== 5) begin bad++; $display("FAIL to_once: got pulses=%0d at=%0d want 1 at 5", pulses, pulse_at); end
        total++; if (grant_o !== 2'b00 || timeout_o !== 1'b0 || m0_bus.err !== 1'b0) begin bad++; $display("FAIL to_after: got grant=%b timeout=%b err=%b want 00/0/0", grant_o, timeout_o, m0_bus.err); end
        step();
    endtask

    task automatic test_ack_at_limit();
        req_m0(1'b0, 32'h0000_0500, 32'h0);
        step();
        for (int c = 0; c < 4; c++) step();
        s_bus.ack = 1; s_bus.dat_r = 32'hCAFE_F00D;
        #1;
        total++; if (m0_bus.ack !== 1'b1 || m0_bus.dat_r !== 32'hCAFE_F00D) begin bad++; $display("FAIL limit_ack: got ack=%b dat=%h want 1/cafef00d", m0_bus.ack, m0_bus.dat_r); end
        total++; if (timeout_o !== 1'b0 || m0_bus.err !== 1'b0) begin bad++; $display("FAIL limit_no_err_now: got timeout=%b err=%b want 0/0", timeout_o, m0_bus.err); end
        step();
        s_bus.ack = 0; s_bus.dat_r = '0; m0_bus.cyc = 0; m0_bus.stb = 0;
        #1;
        total++; if (timeout_o !== 1'b0 || m0_bus.err !== 1'b0 || grant_o !== 2'b01) begin bad++; $display("FAIL limit_no_err_next: got timeout=%b err=%b grant=%b want 0/0/01", timeout_o, m0_bus.err, grant_o); end
        step();
        total++; if (grant_o !== 2'b00 || timeout_o !== 1'b0) begin bad++; $display("FAIL limit_idle: got grant=%b timeout=%b want 00/0", grant_o, timeout_o); end
    endtask

    task automatic test_async_reset();
        req_m0(1'b0, 32'h0000_0700, 32'h0);
        step();
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL arst_pre_grant: got %b want 01", grant_o); end
        s_bus.ack = 1; s_bus.dat_r = 32'h1234_5678;
        #1 rst_ni = 1'b0;
        #1;
        total++; if (grant_o !== 2'b00 || s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin bad++; $display("FAIL arst_drop: got grant=%b cyc=%b stb=%b want 00/0/0", grant_o, s_bus.cyc, s_bus.stb); end
        total++; if (m0_bus.ack !== 1'b0 || m0_bus.dat_r !== 32'h0 || s_bus.adr !== 32'h0) begin bad++; $display("FAIL arst_outputs: got ack=%b dat=%h adr=%h want 0/0/0", m0_bus.ack, m0_bus.dat_r, s_bus.adr); end
        idle_all();
        step();
        #2 rst_ni = 1'b1;
        step();
        req_m0(1'b0, 32'h0000_0800, 32'h0);
        req_m1(1'b0, 32'h0000_0900, 32'h0);
        step();
        total++; if (grant_o !== 2'b01 || s_bus.adr !== 32'h0000_0800) begin bad++; $display("FAIL arst_first_tie: got grant=%b adr=%h want 01/00000800", grant_o, s_bus.adr); end
        idle_all();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_ack_at_limit();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
